// File: rtl/mem_arbiter.sv
// Byte-serial external memory sequencer shared between icache fetches and LSB loads/stores.
// Optional build macro MEM_ARB_LSB_PRIORITY_EN: LSB wins ties instead of round-robin.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [1:0]  IO_ADDR_HI = 2'b11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  rollback,
    input  logic                  io_buffer_full,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  if_valid,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  ls_valid,
    input  logic                  ls_wr,
    input  logic [1:0]            ls_width,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_done,
    output logic [31:0]           ls_rdata
);

    // state   | meaning
    // IDLE    | no access in flight, arbitrating
    // IFETCH  | 4-byte instruction read, cnt = byte index on mem_a
    // LOAD    | 1/2/4-byte data read, cnt = byte index on mem_a
    // STORE   | 1/2/4-byte write, cnt = byte index being written
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_IFETCH = 2'd1,
        S_LOAD   = 2'd2,
        S_STORE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] mem_a_q;
    logic [7:0]            mem_dout_q;
    logic                  mem_wr_q;
    logic                  if_done_q;
    logic                  ls_done_q;
    logic [31:0]           if_data_q;
    logic [31:0]           ls_rdata_q;
    logic [31:0]           buf_q;
    logic [2:0]            cnt_q;
    logic [2:0]            n_q;
`ifndef MEM_ARB_LSB_PRIORITY_EN
    logic                  last_ls_q;
`endif

    logic       ls_is_io;
    logic       ls_elig;
    logic       if_elig;
    logic       grant_ls;
    logic       grant_if;
    logic [2:0] ls_n;
    logic [1:0] rd_sel;
    logic [1:0] wr_sel;
    logic [31:0] buf_d;

    always_comb begin
        ls_n = 3'd4;
        case (ls_width)
            2'b00:   ls_n = 3'd1;
            2'b01:   ls_n = 3'd2;
            default: ls_n = 3'd4;
        endcase

        // Stores are committed, so rollback only blocks new reads.
        ls_is_io = (ls_addr[17:16] == IO_ADDR_HI);
        ls_elig  = ls_valid && !ls_done_q
                   && !(ls_wr && ls_is_io && io_buffer_full)
                   && !(rollback && !ls_wr);
        if_elig  = if_valid && !if_done_q && !rollback;

`ifdef MEM_ARB_LSB_PRIORITY_EN
        grant_ls = ls_elig;
`else
        grant_ls = ls_elig && (!if_elig || !last_ls_q);
`endif
        grant_if = if_elig && !grant_ls;

        rd_sel = 2'(cnt_q - 3'd1);
        wr_sel = 2'(cnt_q + 3'd1);

        // mem_din in cycle cnt carries the byte addressed in cycle cnt-1.
        buf_d = buf_q;
        if (cnt_q != 3'd0) begin
            buf_d[{rd_sel, 3'b000} +: 8] = mem_din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
            buf_q      <= '0;
            cnt_q      <= '0;
            n_q        <= '0;
`ifndef MEM_ARB_LSB_PRIORITY_EN
            last_ls_q  <= 1'b1;
`endif
        end else if (rdy) begin
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    mem_wr_q <= 1'b0;
                    cnt_q    <= '0;
                    buf_q    <= '0;
                    if (grant_ls) begin
                        state_q  <= ls_wr ? S_STORE : S_LOAD;
                        mem_a_q  <= ls_addr;
                        mem_wr_q <= ls_wr;
                        n_q      <= ls_n;
                        if (ls_wr) begin
                            mem_dout_q <= ls_wdata[7:0];
                        end
`ifndef MEM_ARB_LSB_PRIORITY_EN
                        last_ls_q <= 1'b1;
`endif
                    end else if (grant_if) begin
                        state_q <= S_IFETCH;
                        mem_a_q <= if_addr;
                        n_q     <= 3'd4;
`ifndef MEM_ARB_LSB_PRIORITY_EN
                        last_ls_q <= 1'b0;
`endif
                    end
                end

                S_IFETCH, S_LOAD: begin
                    mem_wr_q <= 1'b0;
                    if (rollback) begin
                        state_q <= S_IDLE;
                    end else begin
                        buf_q   <= buf_d;
                        cnt_q   <= cnt_q + 3'd1;
                        mem_a_q <= mem_a_q + ADDR_ONE;
                        if (cnt_q == n_q) begin
                            state_q <= S_IDLE;
                            if (state_q == S_IFETCH) begin
                                if_done_q <= 1'b1;
                                if_data_q <= buf_d;
                            end else begin
                                ls_done_q  <= 1'b1;
                                ls_rdata_q <= buf_d;
                            end
                        end
                    end
                end

                S_STORE: begin
                    if (cnt_q == n_q - 3'd1) begin
                        mem_wr_q  <= 1'b0;
                        ls_done_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q      <= cnt_q + 3'd1;
                        mem_a_q    <= mem_a_q + ADDR_ONE;
                        mem_dout_q <= ls_wdata[{wr_sel, 3'b000} +: 8];
                    end
                end

                default: begin
                    state_q  <= S_IDLE;
                    mem_wr_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q;
    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against a byte-memory model and golden memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        rollback = 1'b0;
    logic        io_buffer_full = 1'b0;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_valid = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_valid = 1'b0;
    logic        ls_wr = 1'b0;
    logic [1:0]  ls_width = 2'b00;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_done;
    logic [31:0] ls_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] bus_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    mem_arbiter #(.ADDR_WIDTH(32), .IO_ADDR_HI(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .if_valid(if_valid), .if_addr(if_addr),
        .if_done(if_done), .if_data(if_data), .ls_valid(ls_valid), .ls_wr(ls_wr),
        .ls_width(ls_width), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_done(ls_done), .ls_rdata(ls_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] bus_rd(input logic [31:0] a);
        if (bus_mem.exists(a)) return bus_mem[a];
        return dflt(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    function automatic int nbytes(input logic [1:0] w);
        if (w == 2'b00) return 1;
        if (w == 2'b01) return 2;
        return 4;
    endfunction

    // Synchronous external byte memory: one-cycle read latency, paused with rdy.
    always @(posedge clk) begin : bus_memory
        logic [7:0] rv;
        if (rdy) begin
            rv = bus_rd(mem_a);
            if (mem_wr) bus_mem[mem_a] = mem_dout;
            mem_din <= rv;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_mem_a"}, mem_a, 32'h0);
        chk({tag, "_mem_dout"}, {24'h0, mem_dout}, 32'h0);
        chk({tag, "_mem_wr"}, {31'h0, mem_wr}, 32'h0);
        chk({tag, "_if_done"}, {31'h0, if_done}, 32'h0);
        chk({tag, "_ls_done"}, {31'h0, ls_done}, 32'h0);
        chk({tag, "_if_data"}, if_data, 32'h0);
        chk({tag, "_ls_rdata"}, ls_rdata, 32'h0);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    // Fetch (is_if) or load; optional rdy stall of stall_l cycles after cycle s.
    task automatic do_read(input bit is_if, input logic [31:0] addr, input logic [1:0] w,
                           input int s, input int stall_l);
        int n;
        int jeff;
        bit got;
        logic [31:0] exp;
        n = is_if ? 4 : nbytes(w);
        exp = '0;
        for (int k = 0; k < n; k++) exp[8*k +: 8] = ref_rd(addr + 32'(k));
        if (is_if) begin
            if_addr = addr; if_valid = 1'b1;
        end else begin
            ls_addr = addr; ls_width = w; ls_wr = 1'b0; ls_valid = 1'b1;
        end
        got = 1'b0;
        for (int j = 1; j <= 40 && !got; j++) begin
            @(posedge clk); #1;
            chk("rd_mem_wr", {31'h0, mem_wr}, 32'h0);
            if (j <= s) jeff = j;
            else if (j <= s + stall_l) jeff = s;
            else jeff = j - stall_l;
            if (jeff >= 1 && jeff <= n) chk("rd_mem_a", mem_a, addr + 32'(jeff - 1));
            if (is_if ? if_done : ls_done) begin
                got = 1'b1;
                chk("rd_latency", 32'(j), 32'(n + 2 + stall_l));
                chk(is_if ? "if_data" : "ls_rdata", is_if ? if_data : ls_rdata, exp);
            end
            if (stall_l > 0 && j == s) rdy = 1'b0;
            if (stall_l > 0 && j == s + stall_l) rdy = 1'b1;
        end
        rdy = 1'b1;
        chk("rd_done_seen", {31'h0, got}, 32'h1);
        if_valid = 1'b0; ls_valid = 1'b0;
        idle_cycle();
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [1:0] w, input logic [31:0] data);
        int n;
        bit got;
        n = nbytes(w);
        ls_addr = addr; ls_width = w; ls_wr = 1'b1; ls_wdata = data; ls_valid = 1'b1;
        got = 1'b0;
        for (int j = 1; j <= 40 && !got; j++) begin
            @(posedge clk); #1;
            if (j <= n) begin
                chk("st_mem_wr", {31'h0, mem_wr}, 32'h1);
                chk("st_mem_a", mem_a, addr + 32'(j - 1));
                chk("st_mem_dout", {24'h0, mem_dout}, {24'h0, data[8*(j-1) +: 8]});
            end
            if (ls_done) begin
                got = 1'b1;
                chk("st_latency", 32'(j), 32'(n + 1));
                chk("st_wr_after", {31'h0, mem_wr}, 32'h0);
            end
        end
        chk("st_done_seen", {31'h0, got}, 32'h1);
        for (int k = 0; k < n; k++) ref_mem[addr + 32'(k)] = data[8*k +: 8];
        ls_valid = 1'b0; ls_wr = 1'b0;
        idle_cycle();
    endtask

    initial begin
        int if_c;
        int ls_c;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  w;

        bus_mem[32'h1000] = 8'h13; bus_mem[32'h1001] = 8'h05;
        bus_mem[32'h1002] = 8'h00; bus_mem[32'h1003] = 8'h00;
        bus_mem[32'h0100] = 8'h80;
        ref_mem[32'h1000] = 8'h13; ref_mem[32'h1001] = 8'h05;
        ref_mem[32'h1002] = 8'h00; ref_mem[32'h1003] = 8'h00;
        ref_mem[32'h0100] = 8'h80;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");

        // Simultaneous requests straight out of reset.
        if_addr = 32'h1000; ls_addr = 32'h100; ls_wr = 1'b0; ls_width = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        if_valid = 1'b1; ls_valid = 1'b1;
        if_c = 0; ls_c = 0;
        for (int j = 1; j <= 40 && (if_c == 0 || ls_c == 0); j++) begin
            @(posedge clk); #1;
            if (if_done) begin
                if_c = j; if_valid = 1'b0;
                chk("co_if_data", if_data, 32'h00000513);
            end
            if (ls_done) begin
                ls_c = j; ls_valid = 1'b0;
                chk("co_ls_rdata", ls_rdata, 32'h00000080);
            end
        end
`ifdef MEM_ARB_LSB_PRIORITY_EN
        chk("co_ls_cycle", 32'(ls_c), 32'd3);
        chk("co_if_cycle", 32'(if_c), 32'd9);
`else
        chk("co_if_cycle", 32'(if_c), 32'd6);
        chk("co_ls_cycle", 32'(ls_c), 32'd9);
`endif
        idle_cycle();

        do_read(1'b1, 32'h00001000, 2'b10, 0, 0);
        do_store(32'h00000200, 2'b10, 32'hDEADBEEF);
        do_read(1'b0, 32'h00000200, 2'b10, 0, 0);
        do_read(1'b0, 32'h00000200, 2'b10, 2, 3);
        do_read(1'b0, 32'h00000200, 2'b01, 0, 0);

        // IO store held off while the UART buffer is full; fetch proceeds.
        io_buffer_full = 1'b1;
        ls_addr = 32'h00030000; ls_width = 2'b00; ls_wr = 1'b1; ls_wdata = 32'h123456A5;
        if_addr = 32'h1000;
        ls_valid = 1'b1; if_valid = 1'b1;
        if_c = 0; ls_c = 0;
        for (int j = 1; j <= 40 && ls_c == 0; j++) begin
            @(posedge clk); #1;
            if (j <= 10) chk("io_wr_held", {31'h0, mem_wr}, 32'h0);
            if (j == 11) begin
                chk("io_wr_issue", {31'h0, mem_wr}, 32'h1);
                chk("io_mem_a", mem_a, 32'h00030000);
                chk("io_mem_dout", {24'h0, mem_dout}, 32'h000000A5);
            end
            if (if_done) begin
                if_c = j; if_valid = 1'b0;
                chk("io_if_data", if_data, 32'h00000513);
            end
            if (ls_done) begin
                ls_c = j; ls_valid = 1'b0;
            end
            if (j == 10) io_buffer_full = 1'b0;
        end
        chk("io_if_cycle", 32'(if_c), 32'd6);
        chk("io_ls_cycle", 32'(ls_c), 32'd12);
        ref_mem[32'h00030000] = 8'hA5;
        ls_wr = 1'b0;
        idle_cycle();
        do_read(1'b0, 32'h00030000, 2'b00, 0, 0);

        // Rollback during the second byte of a fetch.
        if_addr = 32'h3000; if_valid = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            @(posedge clk); #1;
            chk("rb_no_done", {31'h0, if_done}, 32'h0);
            if (j >= 3) chk("rb_mem_wr", {31'h0, mem_wr}, 32'h0);
            if (j == 2) begin
                chk("rb_mem_a", mem_a, 32'h3001);
                rollback = 1'b1; if_valid = 1'b0;
            end
            if (j == 3) rollback = 1'b0;
        end
        do_read(1'b1, 32'h00002000, 2'b10, 0, 0);

        do_read(1'b1, 32'hFFFFFFFE, 2'b10, 0, 0);

        for (int it = 0; it < 24; it++) begin
            a = 32'h8000 + 32'($urandom_range(0, 63));
            w = 2'($urandom_range(0, 2));
            d = $urandom;
            case ($urandom_range(0, 2))
                0: do_read(1'b1, a, 2'b10, 0, 0);
                1: do_read(1'b0, a, w, $urandom_range(1, 2), $urandom_range(0, 2));
                default: do_store(a, w, d);
            endcase
        end

        // Asynchronous reset in the middle of a store.
        ls_addr = 32'h7000; ls_width = 2'b10; ls_wr = 1'b1; ls_wdata = $urandom; ls_valid = 1'b1;
        idle_cycle();
        idle_cycle();
        chk("ar_in_store", {31'h0, mem_wr}, 32'h1);
        #3 rst = 1'b0;
        #1;
        chk_reset_state("async_rst");
        ls_valid = 1'b0; ls_wr = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle_cycle();
        do_read(1'b1, 32'h00001000, 2'b10, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no end of test, required finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single byte-wide external memory port and shares it between the instruction cache (word fetch) and the load/store buffer (byte/half/word load or store).
- Serialises each request into byte accesses and reassembles read data.
- Honours ROB rollback and the UART `io_buffer_full` back-pressure.
- Sits between the memory/IO interface and the icache/LSB.

Parameters:
- ADDR_WIDTH, 32, width of memory addresses.
- IO_ADDR_HI, 2'b11, value of addr[17:16] that marks an IO-mapped address.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (rst==0 resets).
- rdy  in  1  global ready; when 0 all state holds.
- rollback  in  1  ROB rollback pulse.
- io_buffer_full  in  1  UART buffer full.
- mem_din  in  8  byte read from memory.
- mem_dout  out  8  byte to write.
- mem_a  out  ADDR_WIDTH  byte address.
- mem_wr  out  1  1 = write, 0 = read.
- if_valid  in  1  icache fetch request.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_done  out  1  one-cycle completion pulse.
- if_data  out  32  fetched word.
- ls_valid  in  1  LSB request.
- ls_wr  in  1  1 = store.
- ls_width  in  2  00 byte, 01 half, 10 word.
- ls_addr  in  ADDR_WIDTH  access address.
- ls_wdata  in  32  store data, low bytes first.
- ls_done  out  1  one-cycle completion pulse.
- ls_rdata  out  32  load data, zero-extended.

Behaviour:
- Reset (async, rst==0): state=IDLE, mem_a=0, mem_dout=0, mem_wr=0, if_done=0, ls_done=0, if_data=0, ls_rdata=0, last_grant=LSB (the next tie goes to IFETCH), byte counter=0.
- rdy==0: every register holds, including mem_wr and mem_a.
- FSM states: IDLE, IFETCH, LOAD, STORE.
- Request protocol:
  - A requester holds valid and its fields stable until its done pulse.
  - A port whose done is high this cycle is not granted this cycle.
- IDLE grant:
  - Only one eligible port requests: grant it.
  - Both eligible: grant the port that was not last granted (round-robin); update last_grant.
  - On the grant edge: mem_a=addr, mem_wr=(ls_wr for a store grant, else 0), mem_dout=byte 0 for a store; counter=0.
- Byte count n: IFETCH n=4; LSB n = 1, 2 or 4 per ls_width.
- Reads (IFETCH/LOAD):
  - Byte k is addressed at addr+k in cycle k after grant.
  - mem_din carries byte k one cycle later and is captured into bits [8k+7:8k].
  - Addresses addr..addr+n-1 are presented on consecutive cycles; after the last address, mem_a is don't-care.
  - done pulses with the assembled data on the edge n+1 cycles after the grant edge; state returns to IDLE on the same edge.
  - Unused upper bytes of ls_rdata are 0.
- Stores:
  - mem_wr=1 with mem_a=addr+k, mem_dout=ls_wdata[8k+7:8k] for k=0..n-1 on consecutive cycles.
  - On the edge after the last byte: mem_wr=0, ls_done=1, state=IDLE. Latency is n cycles after the grant edge.
- IO stall:
  - A store whose addr[17:16]==IO_ADDR_HI is not granted while io_buffer_full=1; it waits in IDLE with mem_wr=0.
  - The other port may be granted meanwhile.
- Rollback:
  - In IFETCH or LOAD: abort; next edge state=IDLE, mem_wr=0, no done pulse, partial data discarded.
  - STORE is never aborted (only committed stores reach this block).
  - In IDLE with rollback=1: only store requests may be granted that cycle.
- mem_wr is 0 in every cycle outside STORE.
- Address arithmetic is ADDR_WIDTH wrap-around: 0xFFFFFFFF+1 = 0.

Optional Feature:
- Macro MEM_ARB_LSB_PRIORITY_EN.
  - Defined: fixed priority; LSB always wins ties over IFETCH and last_grant is unused.
  - Undefined: round-robin as above.

Test Plan:
- IFETCH at 0x00001000 (memory bytes 13,05,00,00) -> mem_a 0x1000..0x1003 on 4 consecutive cycles, mem_wr=0; if_done pulses 5 cycles after grant with if_data=0x00000513.
- Store word 0xDEADBEEF to 0x00000200 -> mem_wr=1 for 4 cycles with mem_dout EF,BE,AD,DE at 0x200..0x203; ls_done on the next edge; a readback load returns 0xDEADBEEF.
- if_valid and ls_valid (byte load, 0x100 holding 0x80) raised together from reset -> IFETCH served first, then LOAD; ls_rdata=0x00000080. With MEM_ARB_LSB_PRIORITY_EN: LOAD first.
- Byte store to 0x00030000 with io_buffer_full=1 for 10 cycles -> mem_wr stays 0, pending if_valid served meanwhile; store issues within one cycle of io_buffer_full falling.
- rollback during the 2nd byte of an IFETCH -> no if_done, mem_wr=0, IDLE next cycle; a new fetch of 0x2000 then completes normally.
- rst pulled low mid-STORE -> all outputs reset immediately (async); rdy=0 for 3 cycles mid-LOAD -> mem_a and counter frozen, completion delayed by exactly 3 cycles.
